clock_set_ctrl: RTL

Sequencing and time-set controller for the digital-clock counter chain built from modulo counters (seconds, minutes and hours stages, each with `enb` in and `cy` out). In RUN mode it drives the seconds stage from the 1 Hz tick and ripples the carries. In SET modes it freezes timekeeping, steps the selected field from a debounced advance button (single step plus auto-repeat), blinks the selected field, and returns to RUN on a button sequence or after inactivity.

---
 rtl/clock_set_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: RUN/SET sequencing for the seconds/minutes/hours chain.
// Define CLK_SET_TIMEOUT_EN to build the SET-mode inactivity timeout.
module clock_set_ctrl #(
  parameter int HOLD_CYC      = 500,
  parameter int RPT_CYC       = 100,
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       set_btn,
  input  logic       adv_btn,
  input  logic       sec_cy,
  input  logic       min_cy,
  output logic       sec_enb,
  output logic       min_enb,
  output logic       hr_enb,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blank
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_MIN = 2'd1,
    SET_HR  = 2'd2
  } state_e;

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int RW = $clog2(RPT_CYC);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC);
  localparam logic [RW-1:0] RPT_LAST = RW'(RPT_CYC - 1);

  state_e        state_q, state_d;
  logic          set_q, adv_q;
  logic          phase_q, phase_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rpt_q, rpt_d;
  logic          set_edge, adv_edge;
  logic          rpt_fire, adv_step;
  logic          mode_chg, tmo_exp;

  assign set_edge = set_btn & ~set_q;
  assign adv_edge = adv_btn & ~adv_q;
  assign rpt_fire = adv_btn & (hold_q == HOLD_MAX)
                  & (rpt_q == '0);
  assign adv_step = (adv_edge | rpt_fire) & ~set_edge;
  assign mode_chg = (state_d != state_q);
  assign mode     = state_q;

  // hold_q saturates at HOLD_CYC; rpt_q then paces repeats
  always_comb begin
    hold_d = hold_q;
    rpt_d  = rpt_q;
    if (!adv_btn) begin
      hold_d = '0;
      rpt_d  = '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + 1'b1;
    end else if (rpt_q == RPT_LAST) begin
      rpt_d = '0;
    end else begin
      rpt_d = rpt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (set_edge) state_d = SET_MIN;
      end
      SET_MIN: begin
        if (set_edge)     state_d = SET_HR;
        else if (tmo_exp) state_d = RUN;
      end
      SET_HR: begin
        if (set_edge)     state_d = RUN;
        else if (tmo_exp) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign phase_d = mode_chg ? 1'b0 : (phase_q ^ tick);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      set_q   <= 1'b0;
      adv_q   <= 1'b0;
      phase_q <= 1'b0;
      hold_q  <= '0;
      rpt_q   <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_btn;
      adv_q   <= adv_btn;
      phase_q <= phase_d;
      hold_q  <= hold_d;
      rpt_q   <= rpt_d;
    end
  end

`ifdef CLK_SET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);

  logic [TW-1:0] tmo_q, tmo_d;

  // the tick that would reach TIMEOUT_TICKS triggers the return
  assign tmo_exp = (state_q != RUN) & tick & ~set_edge
                 & ~adv_edge & (tmo_q == TMO_LAST);

  always_comb begin
    tmo_d = tmo_q;
    if (mode_chg || set_edge || adv_edge || state_q == RUN)
      tmo_d = '0;
    else if (tick)
      tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_TICKS != 0);
  assign tmo_exp    = 1'b0;
`endif

  always_comb begin
    sec_enb = 1'b0;
    min_enb = 1'b0;
    hr_enb  = 1'b0;
    sec_clr = 1'b0;
    blank   = 1'b0;
    unique case (state_q)
      RUN: begin
        sec_enb = tick & ~set_edge;
        min_enb = sec_cy;
        hr_enb  = min_cy;
        sec_clr = set_edge;
      end
      SET_MIN: begin
        min_enb = adv_step;
        blank   = phase_q & ~adv_btn;
      end
      SET_HR: begin
        hr_enb = adv_step;
        blank  = phase_q & ~adv_btn;
      end
      default: ;
    endcase
    if (rst) begin
      sec_enb = 1'b0;
      min_enb = 1'b0;
      hr_enb  = 1'b0;
      sec_clr = 1'b0;
      blank   = 1'b0;
    end
  end

endmodule
